// File: rtl/core_seq.sv
// Sequencer that walks `core` and X_MEM through a full 3x3 convolution pass:
// per-kij clear, L0 weight load, activation feed and drain, then ReLU wait and readout.
module core_seq #(
    parameter int          len_kij      = 9,
    parameter int          len_nij      = 36,
    parameter int          mac_col      = 8,
    parameter int          len_onij     = 16,
    parameter int          clr_cycles   = 11,
    parameter int          drain_cycles = 30,
    parameter int          relu_cycles  = 20,
    parameter logic [10:0] w_base       = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        act_2b_mode,
    output logic        busy,
    output logic        done,
    output logic        array_clr,
    output logic [1:0]  inst_w,
    output logic        CEN_xmem,
    output logic        WEN_xmem,
    output logic [10:0] A_xmem,
    output logic [3:0]  kij,
    output logic        readout_start,
    output logic        out_valid
);

    localparam int MAX_A   = (clr_cycles > 2 * mac_col) ? clr_cycles : 2 * mac_col;
    localparam int MAX_B   = (len_nij > drain_cycles) ? len_nij : drain_cycles;
    localparam int MAX_C   = (relu_cycles > len_onij + 1) ? relu_cycles : len_onij + 1;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_LEN = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_CLR   = CNT_W'(clr_cycles - 1);
    localparam logic [CNT_W-1:0] LAST_W4    = CNT_W'(mac_col - 1);
    localparam logic [CNT_W-1:0] LAST_W2    = CNT_W'(2 * mac_col - 1);
    localparam logic [CNT_W-1:0] LAST_NIJ   = CNT_W'(len_nij - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(drain_cycles - 1);
    localparam logic [CNT_W-1:0] LAST_RELU  = CNT_W'(relu_cycles - 1);
    localparam logic [CNT_W-1:0] LAST_RD    = CNT_W'(len_onij);
    localparam logic [3:0]       KIJ_LAST   = 4'(len_kij - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CLR       = 4'd1,
        WLOAD     = 4'd2,
        GAP       = 4'd3,
        XFEED     = 4'd4,
        DRAIN     = 4'd5,
        RELU_WAIT = 4'd6,
        RSTART    = 4'd7,
        READOUT   = 4'd8,
        DONE      = 4'd9
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       kij_r;
    logic             mode_r;
    logic             last_s;

    // Terminal-count detection and successor state for the current phase.
    always_comb begin
        last_s = 1'b0;
        next_s = IDLE;
        case (state_r)
            IDLE: begin
                last_s = 1'b0;
                next_s = CLR;
            end
            CLR: begin
                last_s = (cnt_r == LAST_CLR);
                next_s = WLOAD;
            end
            WLOAD: begin
                last_s = (cnt_r == (mode_r ? LAST_W2 : LAST_W4));
                next_s = GAP;
            end
            GAP: begin
                last_s = 1'b1;
                next_s = XFEED;
            end
            XFEED: begin
                last_s = (cnt_r == LAST_NIJ);
                next_s = DRAIN;
            end
            DRAIN: begin
                last_s = (cnt_r == LAST_DRAIN);
                next_s = (kij_r < KIJ_LAST) ? CLR : RELU_WAIT;
            end
            RELU_WAIT: begin
                last_s = (cnt_r == LAST_RELU);
                next_s = RSTART;
            end
            RSTART: begin
                last_s = 1'b1;
                next_s = READOUT;
            end
            READOUT: begin
                last_s = (cnt_r == LAST_RD);
                next_s = DONE;
            end
            DONE: begin
                last_s = 1'b1;
                next_s = IDLE;
            end
            default: begin
                last_s = 1'b1;
                next_s = IDLE;
            end
        endcase
    end

    // Sequencer state plus output registers decoded from the current phase (one cycle behind the state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            kij_r         <= 4'd0;
            mode_r        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            array_clr     <= 1'b0;
            inst_w        <= 2'b00;
            CEN_xmem      <= 1'b1;
            WEN_xmem      <= 1'b1;
            A_xmem        <= 11'd0;
            kij           <= 4'd0;
            readout_start <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            busy          <= (state_r != IDLE) && (state_r != DONE);
            done          <= (state_r == DONE);
            array_clr     <= (state_r == CLR);
            inst_w        <= (state_r == WLOAD) ? 2'b01 : ((state_r == XFEED) ? 2'b10 : 2'b00);
            CEN_xmem      <= !((state_r == WLOAD) || (state_r == XFEED));
            WEN_xmem      <= 1'b1;
            A_xmem        <= (state_r == WLOAD) ? (w_base + 11'(cnt_r)) :
                             ((state_r == XFEED) ? 11'(cnt_r) : 11'd0);
            kij           <= kij_r;
            readout_start <= (state_r == RSTART);
            out_valid     <= (state_r == READOUT) && (cnt_r != {CNT_W{1'b0}});

            if (state_r == IDLE) begin
                if (start) begin
                    state_r <= CLR;
                    cnt_r   <= {CNT_W{1'b0}};
                    kij_r   <= 4'd0;
                    mode_r  <= act_2b_mode;
                end else begin
                    cnt_r   <= {CNT_W{1'b0}};
                end
            end else if (last_s) begin
                state_r <= next_s;
                cnt_r   <= {CNT_W{1'b0}};
                if ((state_r == DRAIN) && (next_s == CLR)) begin
                    kij_r <= kij_r + 4'd1;
                end else if (state_r == DONE) begin
                    kij_r <= 4'd0;
                end else begin
                    kij_r <= kij_r;
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: a timeline model derived from the pass schedule is checked
// every cycle, plus literal pins at the landmark cycles of each pass.
module tb_core_seq;

    localparam int CLR   = 11;
    localparam int NIJ   = 36;
    localparam int DRAIN = 30;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        clr;
        logic [1:0]  inst;
        logic        cen;
        logic        wen;
        logic [10:0] a;
        logic [3:0]  kij;
        logic        rs;
        logic        ov;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        act_2b_mode;
    logic        busy;
    logic        done;
    logic        array_clr;
    logic [1:0]  inst_w;
    logic        CEN_xmem;
    logic        WEN_xmem;
    logic [10:0] A_xmem;
    logic [3:0]  kij;
    logic        readout_start;
    logic        out_valid;

    int n_chk;
    int n_pass;
    int ecount;
    int start_edge;
    int exp_nw;
    bit pass_on;
    bit chk_en;
    int act_cnt, wt_cnt, done_cnt, rs_cnt, ov_cnt;

    core_seq dut (
        .clk(clk), .reset(reset), .start(start), .act_2b_mode(act_2b_mode),
        .busy(busy), .done(done), .array_clr(array_clr), .inst_w(inst_w),
        .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem), .kij(kij),
        .readout_start(readout_start), .out_valid(out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecount++;

    function automatic exp_t cur();
        exp_t c;
        c = {busy, done, array_clr, inst_w, CEN_xmem, WEN_xmem, A_xmem, kij, readout_start, out_valid};
        return c;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.cen = 1'b1;
        e.wen = 1'b1;
        return e;
    endfunction

    // What the outputs must be t cycles after the start edge, from the pass schedule.
    function automatic exp_t model(input bit on, input int t, input int nw);
        exp_t e;
        int   p, ph;
        e = idle_e();
        p = CLR + nw + 1 + NIJ + DRAIN;
        if (!on || t < 1 || t > 9 * p + 39) return e;
        e.busy = (t <= 9 * p + 38);
        if (t <= 9 * p) begin
            e.kij = 4'((t - 1) / p);
            ph    = (t - 1) % p;
            if (ph < CLR) begin
                e.clr = 1'b1;
            end else if (ph < CLR + nw) begin
                e.inst = 2'b01;
                e.cen  = 1'b0;
                e.a    = 11'h400 + 11'(ph - CLR);
            end else if (ph > CLR + nw && ph < CLR + nw + 1 + NIJ) begin
                e.inst = 2'b10;
                e.cen  = 1'b0;
                e.a    = 11'(ph - CLR - nw - 1);
            end
        end else begin
            e.kij  = 4'd8;
            e.rs   = (t == 9 * p + 21);
            e.ov   = (t >= 9 * p + 23) && (t <= 9 * p + 38);
            e.done = (t == 9 * p + 39);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) chk("cycle", ecount - start_edge, 32'(cur()),
                        32'(model(pass_on, ecount - start_edge, exp_nw)));
    end

    // Event counters for the current pass.
    always @(negedge clk) begin
        if (inst_w == 2'b10) act_cnt++;
        if (inst_w == 2'b01) wt_cnt++;
        if (done) done_cnt++;
        if (readout_start) rs_cnt++;
        if (out_valid) ov_cnt++;
    end

    task automatic begin_pass(input logic m);
        act_2b_mode = m;
        start       = 1'b1;
        start_edge  = ecount + 1;
        exp_nw      = m ? 16 : 8;
        pass_on     = 1'b1;
        act_cnt = 0; wt_cnt = 0; done_cnt = 0; rs_cnt = 0; ov_cnt = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        int g;
        g = 0;
        while ((ecount - start_edge) != k && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_chk++;
            $display("FAIL timeout waiting for t=%0d", k);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; act_2b_mode = 1'b0;
        pass_on = 1'b0; start_edge = 0; exp_nw = 8; chk_en = 1'b0;
        n_chk = 0; n_pass = 0; ecount = 0;
        #2 reset = 1'b0;
        #1 chk("reset_vals", 0, 32'(cur()), 32'(idle_e()));
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 4-bit pass with ignored re-starts and a mid-pass mode change
        begin_pass(1'b0);
        wait_cyc(12);  chk("w_first", 12, {19'd0, inst_w, A_xmem}, {19'd0, 2'b01, 11'h400});
        wait_cyc(19);  chk("w_last", 19, {19'd0, inst_w, A_xmem}, {19'd0, 2'b01, 11'h407});
        wait_cyc(20);  chk("gap", 20, {18'd0, inst_w, CEN_xmem, A_xmem}, {18'd0, 2'b00, 1'b1, 11'd0});
        wait_cyc(21);  chk("x_first", 21, {18'd0, inst_w, CEN_xmem, A_xmem}, {18'd0, 2'b10, 1'b0, 11'd0});
        wait_cyc(49);  start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(56);  chk("x_last", 56, {18'd0, inst_w, CEN_xmem, A_xmem}, {18'd0, 2'b10, 1'b0, 11'd35});
        wait_cyc(87);  chk("kij1", 87, {27'd0, kij, array_clr}, {27'd0, 4'd1, 1'b1});
        wait_cyc(100); act_2b_mode = 1'b1;
        wait_cyc(811); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_cyc(813); chk("done4", 813, {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});
        wait_cyc(820); act_2b_mode = 1'b0;
        chk("act_cnt4", 820, act_cnt, 324);
        chk("wt_cnt4", 820, wt_cnt, 72);
        chk("done_cnt4", 820, done_cnt, 1);
        chk("rs_cnt4", 820, rs_cnt, 1);
        chk("ov_cnt4", 820, ov_cnt, 16);

        // 2-bit pass
        begin_pass(1'b1);
        act_2b_mode = 1'b0;
        wait_cyc(12);  chk("w2_first", 12, {21'd0, A_xmem}, {21'd0, 11'h400});
        wait_cyc(27);  chk("w2_last", 27, {19'd0, inst_w, A_xmem}, {19'd0, 2'b01, 11'h40F});
        wait_cyc(28);  chk("gap2", 28, {30'd0, inst_w}, {30'd0, 2'b00});
        wait_cyc(95);  chk("kij1_2b", 95, {27'd0, kij, array_clr}, {27'd0, 4'd1, 1'b1});
        wait_cyc(885); chk("done2", 885, {31'd0, done}, {31'd0, 1'b1});
        wait_cyc(890);
        chk("wt_cnt2", 890, wt_cnt, 144);
        chk("act_cnt2", 890, act_cnt, 324);
        chk("done_cnt2", 890, done_cnt, 1);

        // asynchronous reset mid-pass, then a clean restart
        begin_pass(1'b0);
        wait_cyc(299); chk("busy_pre_rst", 299, {31'd0, busy}, {31'd0, 1'b1});
        @(posedge clk);
        #2 reset = 1'b0;
        pass_on = 1'b0;
        #1 chk("rst_async", 300, 32'(cur()), 32'(idle_e()));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("done_cnt_abort", 300, done_cnt, 0);
        @(negedge clk);
        begin_pass(1'b0);
        wait_cyc(1);   chk("restart", 1, {25'd0, busy, array_clr, kij}, {25'd0, 1'b1, 1'b1, 4'd0});
        wait_cyc(87);  chk("restart_kij1", 87, {28'd0, kij}, {28'd0, 4'd1});
        wait_cyc(813); chk("restart_done", 813, {31'd0, done}, {31'd0, 1'b1});
        wait_cyc(816);
        chk("done_cnt_r", 816, done_cnt, 1);
        chk("act_cnt_r", 816, act_cnt, 324);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
